button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//  Conditions raw asynchronous push-button inputs on a board top before they reach the SoC.
//  Typical targets are the SoC reset and halt inputs.
//  Per channel: 2-FF synchronizer, then a stability counter.
//  Outputs: a clean level plus one-cycle press/release pulses.
//  Replaces single-register "debouncing" in board tops; sits between board pins and rvsteel_soc.
// PARAMETERS
//  CLOCK_FREQUENCY  12000000  input clock in Hz
//  DEBOUNCE_MS      10        required stable time in ms
//  NUM_BUTTONS      2         number of independent channels
//  localparam DEBOUNCE_CYCLES = max(1, CLOCK_FREQUENCY/1000*DEBOUNCE_MS)
//  localparam CNT_W = clog2(DEBOUNCE_CYCLES+1)
// PORTS
//  clock           in   1            system clock; all logic on its rising edge
//  reset           in   1            asynchronous, active-low reset of this block
//  button_raw      in   NUM_BUTTONS  raw pin levels, asynchronous to clock, active-high = pressed
//  button_level    out  NUM_BUTTONS  debounced level
//  button_press    out  NUM_BUTTONS  1-cycle pulse when button_level goes 0->1
//  button_release  out  NUM_BUTTONS  1-cycle pulse when button_level goes 1->0
// BEHAVIOUR
//  Reset (reset==0, async assert, sync deassert by clocking):
//   - sync flops, counters, button_level, button_press, button_release all 0.
//  Sync stage: sync0<=button_raw; sync1<=sync0 (bitwise). sync1 is the only value the counter sees.
//  Per channel, each cycle:
//   - sync1==button_level: counter<=0; no pulse.
//   - sync1!=button_level and counter<DEBOUNCE_CYCLES-1: counter<=counter+1.
//   - sync1!=button_level and counter==DEBOUNCE_CYCLES-1:
//     button_level<=sync1; counter<=0; registered press (if sync1=1) or release pulse for exactly 1 cycle.
//  Stability rule:
//   - a change is accepted only after DEBOUNCE_CYCLES consecutive cycles of sync1 differing from button_level.
//   - any return to equality clears the counter; glitches shorter than DEBOUNCE_CYCLES never reach outputs.
//  Latency:
//   - raw edge to button_level change is 2 (sync) + DEBOUNCE_CYCLES clocks.
//   - the press/release pulse coincides with the first cycle of the new level.
//  Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//  press and release of the same channel are mutually exclusive in any cycle.
//  Channels are fully independent; simultaneous changes on several channels each complete on their own schedule.
//  Reset mid-count: counter and outputs cleared immediately.
//   - after release, a held button re-qualifies from scratch and produces a press pulse.
//  DEBOUNCE_CYCLES==1: level follows sync1 with 1 extra cycle; pulses still generated.
// STRUCTURE
//  - No shared package: DEBOUNCE_CYCLES, CNT_W and a clog2 function are local to this file.
//  - Sub-module debounce_channel (one synchronizer + counter + edge pulse), instantiated NUM_BUTTONS times in a generate loop.
//  - Top only fans bits in/out.
// TESTING (bench: CLOCK_FREQUENCY=1000, DEBOUNCE_MS=4 -> DEBOUNCE_CYCLES=4, NUM_BUTTONS=2)
//  1. Hold reset=0 while button_raw=2'b11 -> all outputs 0.
//     Release reset -> button_level=2'b11 exactly 6 clocks later; press=2'b11 for 1 cycle.
//  2. button_raw[0] 0->1 held -> level[0]=1 at clock 6 after edge; press[0] one cycle; release never asserted.
//  3. button_raw[0] high for 3 clocks then low, repeated 5 times -> level[0], press[0] stay 0 throughout.
//  4. Channel 0 rises at t=0, channel 1 rises at t=2 -> press[0] at t=6, press[1] at t=8; pulses never overlap wrongly.
//  5. Level[1]=1, raw[1] falls, reset pulsed low at count 2, raw[1] returned high ->
//     level[1]=0 during reset, then press[1] 6 clocks after reset release.
//  6. Random bouncing (1-3 cycle glitches) around a clean transition ->
//     exactly one press and one release per real transition; scoreboard checks latency 6.

Source files
------------

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stability counter and registered
// press/release pulses that line up with the first cycle of the new level.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic press_out,
  output logic release_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive disagreeing cycles, accept the change on the last one
  always_comb begin
    sync0_d   = raw_in;
    sync1_d   = sync0_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = cnt_q;
    if (sync1_q == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      level_d   = sync1_q;
      cnt_d     = {CNT_W{1'b0}};
      press_d   = sync1_q;
      release_d = ~sync1_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BUTTONS raw push-button pins into clean levels and
// one-cycle press/release pulses; each bit is an independent channel.
module button_debouncer #(
  parameter int unsigned CLOCK_FREQUENCY = 12000000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned NUM_BUTTONS     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release
);

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int unsigned RAW_CYCLES      = CLOCK_FREQUENCY / 32'd1000 * DEBOUNCE_MS;
  // A zero-length window would make the counter compare against -1
  localparam int unsigned DEBOUNCE_CYCLES = (RAW_CYCLES < 32'd1) ? 32'd1 : RAW_CYCLES;
  localparam int unsigned CNT_W           = clog2(DEBOUNCE_CYCLES + 32'd1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .raw_in      (button_raw[i]),
      .level_out   (button_level[i]),
      .press_out   (button_press[i]),
      .release_out (button_release[i])
    );
  end

endmodule
